sdram_port_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing the single Avalon-MM slave port of new_sdram_controller_0.

---
 rtl/sdram_port_arbiter_if.sv | 26 ++
 rtl/sdram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - Avalon-MM link bundle shared by the two requesters and the SDRAM side
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    // Issuer of requests (a CPU/DMA, or the arbiter toward the SDRAM controller)
    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    // Receiver of requests (the SDRAM controller, or the arbiter toward a requester)
    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master round-robin SDRAM port arbiter with read tag FIFO (option: ARB_FIXED_PRIO_EN)
module sdram_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    sdram_port_arbiter_if.slave   m0,
    sdram_port_arbiter_if.slave   m1,
    sdram_port_arbiter_if.master  s,
    output logic                  err_stray_rdv
);
    localparam int IDX_W = $clog2(MAX_PENDING);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT0, ST_GRANT1} state_t;

    state_t r_state, w_state_nxt;

    logic [MAX_PENDING-1:0] r_tags;
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic                   r_rdv0, r_rdv1, r_err;
    logic [DATA_W-1:0]      r_rdata0, r_rdata1;

    logic w_req0, w_req1, w_prio;
    logic w_granted, w_sel_m1, w_rd, w_wr;
    logic w_s_read, w_s_write, w_accept;
    logic w_empty, w_full, w_push, w_pop, w_head;

`ifdef ARB_FIXED_PRIO_EN
    assign w_prio = 1'b0;
`else
    logic r_prio;

    // Round-robin pointer: after any accepted transfer the other master gets first pick
    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            r_prio <= 1'b0;
        else if (w_accept)
            r_prio <= !w_sel_m1;
    end

    assign w_prio = r_prio;
`endif

    assign w_req0    = m0.read | m0.write;
    assign w_req1    = m1.read | m1.write;
    assign w_granted = (r_state != ST_IDLE);
    assign w_sel_m1  = (r_state == ST_GRANT1);

    // Tag FIFO status: extra pointer MSB distinguishes full from empty
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_head  = r_tags[r_rd_ptr[IDX_W-1:0]];
    assign w_pop   = s.readdatavalid & !w_empty;

    // Read wins over an illegal simultaneous write; reads stall while no tag slot is free
    assign w_rd      = w_sel_m1 ? m1.read  : m0.read;
    assign w_wr      = w_sel_m1 ? m1.write : m0.write;
    assign w_s_read  = w_granted & w_rd & !w_full;
    assign w_s_write = w_granted & w_wr & !w_rd;
    assign w_accept  = (w_s_read | w_s_write) & !s.waitrequest;
    assign w_push    = w_accept & w_s_read;

    assign s.read       = w_s_read;
    assign s.write      = w_s_write;
    assign s.address    = !w_granted ? '0 : (w_sel_m1 ? m1.address    : m0.address);
    assign s.writedata  = !w_granted ? '0 : (w_sel_m1 ? m1.writedata  : m0.writedata);
    assign s.byteenable = !w_granted ? '0 : (w_sel_m1 ? m1.byteenable : m0.byteenable);

    assign m0.waitrequest = (r_state != ST_GRANT0) | s.waitrequest | (m0.read & w_full);
    assign m1.waitrequest = (r_state != ST_GRANT1) | s.waitrequest | (m1.read & w_full);

    assign m0.readdata      = r_rdata0;
    assign m1.readdata      = r_rdata1;
    assign m0.readdatavalid = r_rdv0;
    assign m1.readdatavalid = r_rdv1;
    assign err_stray_rdv    = r_err;

    // Grant state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next grant: pick in IDLE, release on accept (or if the holder withdraws)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && (!w_req1 || !w_prio))
                    w_state_nxt = ST_GRANT0;
                else if (w_req1)
                    w_state_nxt = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (!w_req0 || w_accept)
                    w_state_nxt = ST_IDLE;
            end
            ST_GRANT1: begin
                if (!w_req1 || w_accept)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tag FIFO pointers; reset discards any outstanding tags
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Tag storage: which master issued each outstanding read
    always_ff @(posedge clk_clk) begin
        if (w_push)
            r_tags[r_wr_ptr[IDX_W-1:0]] <= w_sel_m1;
    end

    // Registered read return routed by head tag; stray data flags a sticky error
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rdv0   <= 1'b0;
            r_rdv1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rdv0 <= w_pop & !w_head;
            r_rdv1 <= w_pop & w_head;
            if (w_pop && !w_head)
                r_rdata0 <= s.readdata;
            if (w_pop && w_head)
                r_rdata1 <= s.readdata;
            if (s.readdatavalid && w_empty)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed vector bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    logic clk_clk = 1'b0;
    logic reset_reset = 1'b1;
    logic err_stray_rdv;

    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) m0_if();
    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) m1_if();
    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) s_if();

    sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_PENDING(8)) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .m0            (m0_if),
        .m1            (m1_if),
        .s             (s_if),
        .err_stray_rdv (err_stray_rdv)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic        m0_rd, m0_wr, m1_rd, m1_wr, s_wait, s_rdv;
        logic [15:0] s_rdata;
        logic        e_srd, e_swr, e_w0, e_w1, e_v0, e_v1;
        logic [15:0] e_d0, e_d1;
        logic [23:0] e_addr;
        logic [15:0] e_wdata;
    } vec_t;

    vec_t vecs[18];
    int   n_cmp = 0;
    int   n_err = 0;
`ifdef ARB_FIXED_PRIO_EN
    bit   robin = 1'b0;
`else
    bit   robin = 1'b1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " s_rd/wr"}, {s_if.read, s_if.write}, 2'b00);
        chk({tag, " waitreq"}, {m0_if.waitrequest, m1_if.waitrequest}, 2'b11);
        chk({tag, " rdv"}, {m0_if.readdatavalid, m1_if.readdatavalid}, 2'b00);
        chk({tag, " rdata"}, {m0_if.readdata, m1_if.readdata}, 32'h0);
        chk({tag, " err"}, err_stray_rdv, 1'b0);
    endtask

    initial begin
        int grants, acc;
        bit found;
        int who;

        //             m0r m0w m1r m1w sw  rdv rdata  | srd swr w0 w1 v0 v1 d0     d1     addr      wdata
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0, 16'h0,  24'h0,  16'h0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0, 16'h0,  24'h0,  16'h0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 16'h0,    0, 1, 0, 1, 0, 0, 16'h0, 16'h0,  24'h10, 16'hBEEF};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0, 16'h0,  24'h0,  16'h0};
        vecs[4]  = '{1, 0, 0, 0, 1, 0, 16'h0,    1, 0, 1, 1, 0, 0, 16'h0, 16'h0,  24'h10, 16'hBEEF};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 16'h0,    1, 0, 0, 1, 0, 0, 16'h0, 16'h0,  24'h10, 16'hBEEF};
        vecs[6]  = '{0, 0, 1, 0, 0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0, 16'h0,  24'h0,  16'h0};
        vecs[7]  = '{0, 0, 1, 0, 0, 0, 16'h0,    1, 0, 1, 0, 0, 0, 16'h0, 16'h0,  24'h20, 16'h5A5A};
        vecs[8]  = '{1, 0, 0, 0, 0, 1, 16'hA,    0, 0, 1, 1, 0, 0, 16'h0, 16'h0,  24'h0,  16'h0};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 16'h0,    1, 0, 0, 1, 1, 0, 16'hA, 16'h0,  24'h10, 16'hBEEF};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 16'hB,    0, 0, 1, 1, 0, 0, 16'hA, 16'h0,  24'h0,  16'h0};
        vecs[11] = '{0, 0, 0, 0, 0, 1, 16'hC,    0, 0, 1, 1, 0, 1, 16'hA, 16'hB,  24'h0,  16'h0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 1, 1, 0, 16'hC, 16'hB,  24'h0,  16'h0};
        vecs[13] = '{0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'hC, 16'hB,  24'h0,  16'h0};
        vecs[14] = '{0, 0, 1, 1, 0, 0, 16'h0,    1, 0, 1, 0, 0, 0, 16'hC, 16'hB,  24'h20, 16'h5A5A};
        vecs[15] = '{0, 0, 0, 0, 0, 1, 16'h77,   0, 0, 1, 1, 0, 0, 16'hC, 16'hB,  24'h0,  16'h0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 1, 0, 1, 16'hC, 16'h77, 24'h0,  16'h0};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'hC, 16'h77, 24'h0,  16'h0};

        m0_if.address = 24'h10; m0_if.writedata = 16'hBEEF; m0_if.byteenable = 2'b11;
        m1_if.address = 24'h20; m1_if.writedata = 16'h5A5A; m1_if.byteenable = 2'b11;
        m0_if.read = 0; m0_if.write = 0; m1_if.read = 0; m1_if.write = 0;
        s_if.waitrequest = 0; s_if.readdatavalid = 0; s_if.readdata = 16'h0;

        // Reset state
        repeat (2) @(negedge clk_clk);
        reset_reset = 0;
        #1;
        chk_reset_state("reset");

        // Table: single write, reads with stall, interleaved returns, read+write conflict
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_clk);
            m0_if.read = vecs[i].m0_rd; m0_if.write = vecs[i].m0_wr;
            m1_if.read = vecs[i].m1_rd; m1_if.write = vecs[i].m1_wr;
            s_if.waitrequest = vecs[i].s_wait;
            s_if.readdatavalid = vecs[i].s_rdv; s_if.readdata = vecs[i].s_rdata;
            #1;
            chk($sformatf("vec%0d ctl", i),
                {s_if.read, s_if.write, m0_if.waitrequest, m1_if.waitrequest,
                 m0_if.readdatavalid, m1_if.readdatavalid, err_stray_rdv},
                {vecs[i].e_srd, vecs[i].e_swr, vecs[i].e_w0, vecs[i].e_w1,
                 vecs[i].e_v0, vecs[i].e_v1, 1'b0});
            chk($sformatf("vec%0d rdata", i), {m0_if.readdata, m1_if.readdata},
                {vecs[i].e_d0, vecs[i].e_d1});
            chk($sformatf("vec%0d s_bus", i), {s_if.address, s_if.writedata},
                {vecs[i].e_addr, vecs[i].e_wdata});
        end

        // Both masters reading continuously: grant order
        @(negedge clk_clk);
        m0_if.read = 1; m1_if.read = 1; s_if.waitrequest = 0;
        s_if.readdatavalid = 0;
        grants = 0;
        for (int c = 0; c < 40 && grants < 8; c++) begin
            if (c != 0) @(negedge clk_clk);
            #1;
            if (s_if.read) begin
                who = m0_if.waitrequest ? 1 : 0;
                chk($sformatf("grant%0d owner", grants), who, robin ? (grants % 2) : 0);
                grants++;
            end
        end
        chk("grant count", grants, 8);

        // Drain the 8 outstanding reads: returns follow issue order
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_clk);
            m0_if.read = 0; m1_if.read = 0;
            s_if.readdatavalid = 1; s_if.readdata = 16'h100 + 16'(i);
            @(negedge clk_clk);
            s_if.readdatavalid = 0;
            #1;
            who = (robin && (i % 2 == 1)) ? 1 : 0;
            chk($sformatf("drain%0d rdv", i), {m0_if.readdatavalid, m1_if.readdatavalid},
                (who == 1) ? 2'b01 : 2'b10);
            chk($sformatf("drain%0d data", i), (who == 1) ? m1_if.readdata : m0_if.readdata,
                16'h100 + 16'(i));
        end
        @(negedge clk_clk);
        #1;
        chk("drain err", err_stray_rdv, 1'b0);

        // Fill the tag FIFO with 8 m1 reads
        m1_if.read = 1;
        acc = 0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            if (c != 0) @(negedge clk_clk);
            #1;
            if (s_if.read && !m1_if.waitrequest) acc++;
        end
        chk("fill accepts", acc, 8);

        // Write still passes with the FIFO full
        @(negedge clk_clk);
        m1_if.read = 0; m0_if.write = 1;
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            if (c != 0) @(negedge clk_clk);
            #1;
            if (s_if.write && !m0_if.waitrequest) found = 1;
        end
        chk("write while full", found, 1'b1);

        // 9th read stalls
        @(negedge clk_clk);
        m0_if.write = 0; m1_if.read = 1;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk_clk);
            #1;
            chk($sformatf("full stall%0d", c), {s_if.read, m1_if.waitrequest}, 2'b01);
        end
        @(negedge clk_clk);
        s_if.readdatavalid = 1; s_if.readdata = 16'h1234;
        #1;
        chk("full pop cycle s_read", s_if.read, 1'b0);
        @(negedge clk_clk);
        s_if.readdatavalid = 0;
        #1;
        chk("full return rdv", {m0_if.readdatavalid, m1_if.readdatavalid}, 2'b01);
        chk("full return data", m1_if.readdata, 16'h1234);
        chk("9th read issues", {s_if.read, m1_if.waitrequest}, 2'b10);
        @(negedge clk_clk);
        m1_if.read = 0;

        // Reset clears the full FIFO
        reset_reset = 1;
        @(negedge clk_clk);
        reset_reset = 0;
        #1;
        chk_reset_state("reset2");

        // Stray readdatavalid sets a sticky error
        @(negedge clk_clk);
        s_if.readdatavalid = 1; s_if.readdata = 16'hDEAD;
        #1;
        chk("stray same cycle", err_stray_rdv, 1'b0);
        @(negedge clk_clk);
        s_if.readdatavalid = 0;
        #1;
        chk("stray err/rdv", {err_stray_rdv, m0_if.readdatavalid, m1_if.readdatavalid}, 3'b100);

        // Reset while a read is outstanding
        m0_if.read = 1;
        @(negedge clk_clk);
        #1;
        chk("midread accept", {s_if.read, m0_if.waitrequest, err_stray_rdv}, 3'b101);
        @(negedge clk_clk);
        m0_if.read = 0;
        reset_reset = 1;
        @(negedge clk_clk);
        reset_reset = 0;
        #1;
        chk_reset_state("reset3");
        @(negedge clk_clk);
        s_if.readdatavalid = 1; s_if.readdata = 16'h5555;
        @(negedge clk_clk);
        s_if.readdatavalid = 0;
        #1;
        chk("post-reset fifo empty", {err_stray_rdv, m0_if.readdatavalid, m1_if.readdatavalid}, 3'b100);
        chk("post-reset rdata", m0_if.readdata, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
